phi2_bus_cycle: RTL and testbench
=================================

# phi2_bus_cycle

Synchronous bus-cycle sequencer for the emulated 6502 bus. Consumes the single-cycle `phi2_rise`/`phi2_fall` pulses produced by the PHI2 edge-detect stage and turns each slow PHI2 period into one handshaked request on the system-clock memory port. Reads complete while PHI2 is high; writes are issued after PHI2 falls. It sits between the edge detector and the memory/peripheral fabric.

## Interface
- `ADDR_W`, 16, CPU address width
- `CNT_W`, 16, width of the bus-cycle counter
- `TIMEOUT`, 255, max sys_clock cycles to wait for `mem_ack` (only with `BUS_TIMEOUT_EN`)

- `sys_clock` in 1 — system clock; the only clock.
- `reset` in 1 — asynchronous, active-low reset (0 = reset).
- `phi2_rise` in 1 — one-cycle pulse, PHI2 rising edge.
- `phi2_fall` in 1 — one-cycle pulse, PHI2 falling edge.
- `rw` in 1 — CPU R/W, 1 = read; sampled on `phi2_rise`.
- `addr` in ADDR_W — CPU address; sampled on `phi2_rise`.
- `data_in` in 8 — CPU write data; sampled on `phi2_fall`.
- `mem_rdata` in 8 — read data; valid with `mem_ack`.
- `mem_ack` in 1 — one-cycle completion from memory.
- `err_clr` in 1 — clears `bus_error`.
- `mem_req` out 1 — request, held until `mem_ack`.
- `mem_we` out 1 — 1 = write request.
- `mem_addr` out ADDR_W — registered address.
- `mem_wdata` out 8 — registered write data.
- `data_out` out 8 — registered read data to the CPU.
- `data_oe` out 1 — CPU data bus drive enable.
- `cycle_count` out CNT_W — accepted bus cycles, wraps modulo 2^CNT_W.
- `bus_error` out 1 — sticky protocol/late-ack error.

## Operation
- States: IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ.
- Reset values: all outputs 0, state IDLE.
- IDLE + `phi2_rise`:
  - latch `addr` into `mem_addr`, `rw` into `mem_we = ~rw`
  - `cycle_count` += 1
  - go to RD_REQ with `mem_req` = 1 if read; otherwise WR_WAIT.
- RD_REQ + `mem_ack`: `data_out <= mem_rdata`, `data_oe` = 1, `mem_req` = 0, go to RD_HOLD.
- RD_HOLD + `phi2_fall`: `data_oe` = 0, go to IDLE.
- RD_REQ + `phi2_fall` (ack late):
  - set `bus_error`, `data_out` = 8'hFF
  - keep `mem_req` until ack, then IDLE with `data_oe` = 0.
- WR_WAIT + `phi2_fall`: `mem_wdata <= data_in`, `mem_req` = 1, go to WR_REQ.
- WR_REQ + `mem_ack`: `mem_req` = 0, go to IDLE.
- `phi2_rise` in any state other than IDLE:
  - set `bus_error`; cycle not accepted, count unchanged
  - in-flight request finishes normally.
- `phi2_rise` and `phi2_fall` in the same cycle: set `bus_error`, ignore both edges, state unchanged.
- `mem_ack` while `mem_req` = 0: ignored.
- `err_clr`: clears `bus_error` next cycle; a simultaneous new error wins (stays 1).
- Reset mid-cycle: immediate return to IDLE; `mem_req` and `data_oe` drop asynchronously.

## Timing
- `phi2_rise` at cycle N: `mem_addr`, `mem_we`, `cycle_count` updated at N+1; read `mem_req` high from N+1.
- `mem_ack` at M: `mem_req` low at M+1; `data_out` valid and `data_oe` high at M+1.
- `phi2_fall` at F: `data_oe` low at F+1.
- Write: `mem_wdata` valid and `mem_req` high at F+1.
- Minimum read latency (rise to `data_oe`): 2 cycles, with ack at N+1.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `BUS_TIMEOUT_EN` defined: a counter runs while `mem_req` = 1.
  - It aborts after TIMEOUT cycles without ack: `mem_req` = 0, `bus_error` = 1.
  - Read abort: `data_out` = 8'hFF; `data_oe` = 1 if PHI2 is still high, else state IDLE.
  - Write abort: state IDLE.
- Undefined: no counter; requests wait indefinitely for `mem_ack`.

## Test plan
- Read: rise at N, addr=16'h1234, rw=1; ack at N+3 with rdata=8'hA5. Required: `mem_req` high N+1..N+3, `data_out`=8'hA5 and `data_oe`=1 at N+4; fall at N+10 gives `data_oe`=0 at N+11; `cycle_count`=1.
- Write: rise with addr=16'h0200, rw=0; fall with data_in=8'h3C. Required: `mem_wdata`=8'h3C, `mem_we`=1, `mem_req`=1 at F+1; ack drops `mem_req` the next cycle.
- Late ack: read whose fall precedes ack. Required: `bus_error`=1, `data_out`=8'hFF, `data_oe`=0; `err_clr` returns `bus_error` to 0.
- Protocol errors: second rise during WR_REQ, and simultaneous rise+fall. Required: `bus_error` set in both cases; `cycle_count` unchanged.
- Reset: assert `reset`=0 during RD_REQ. Required: `mem_req`=0, `data_oe`=0, `cycle_count`=0 without a clock edge.
- Count wrap with CNT_W=4: 17 read cycles. Required: `cycle_count`=1.
- With `BUS_TIMEOUT_EN` and TIMEOUT=8: read with no ack. Required: `mem_req` drops after 8 cycles, `bus_error`=1, `data_out`=8'hFF.

Source files
------------

// File: rtl/phi2_bus_cycle.sv
// PHI2 bus-cycle sequencer: turns each PHI2 period into one handshaked memory request.
// Optional request timeout is enabled by defining BUS_TIMEOUT_EN (parameter TIMEOUT).
module phi2_bus_cycle #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              phi2_rise,
  input  logic              phi2_fall,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              bus_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic               late_reg, late_next;
  logic               mem_req_reg, mem_req_next;
  logic               mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [7:0]         mem_wdata_reg, mem_wdata_next;
  logic [7:0]         data_out_reg, data_out_next;
  logic               data_oe_reg, data_oe_next;
  logic [CNT_W-1:0]   cycle_count_reg, cycle_count_next;
  logic               bus_error_reg, bus_error_next;
  logic               tmo_hit;
  logic               err;
  logic               rise_only, fall_only;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_reg;

  // Counts cycles spent with the request asserted; restarts whenever it drops.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset)
      tmo_reg <= '0;
    else if (mem_req_reg)
      tmo_reg <= tmo_reg + TMO_W'(1);
    else
      tmo_reg <= '0;
  end

  assign tmo_hit = mem_req_reg && !mem_ack && (tmo_reg == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      late_reg        <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      data_out_reg    <= '0;
      data_oe_reg     <= 1'b0;
      cycle_count_reg <= '0;
      bus_error_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      late_reg        <= late_next;
      mem_req_reg     <= mem_req_next;
      mem_we_reg      <= mem_we_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      data_out_reg    <= data_out_next;
      data_oe_reg     <= data_oe_next;
      cycle_count_reg <= cycle_count_next;
      bus_error_reg   <= bus_error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    late_next        = late_reg;
    mem_req_next     = mem_req_reg;
    mem_we_next      = mem_we_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    data_out_next    = data_out_reg;
    data_oe_next     = data_oe_reg;
    cycle_count_next = cycle_count_reg;
    err              = 1'b0;

    // Coincident edges are a protocol fault; both are dropped.
    rise_only = phi2_rise & ~phi2_fall;
    fall_only = phi2_fall & ~phi2_rise;
    if (phi2_rise && phi2_fall)
      err = 1'b1;
    if (rise_only && state_reg != IDLE)
      err = 1'b1;

    case (state_reg)
      IDLE: begin
        if (rise_only) begin
          mem_addr_next    = addr;
          mem_we_next      = ~rw;
          cycle_count_next = cycle_count_reg + CNT_W'(1);
          late_next        = 1'b0;
          if (rw) begin
            mem_req_next = 1'b1;
            state_next   = RD_REQ;
          end else begin
            state_next   = WR_WAIT;
          end
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (late_reg) begin
            late_next  = 1'b0;
            state_next = IDLE;
          end else begin
            data_out_next = mem_rdata;
            data_oe_next  = ~fall_only;
            state_next    = fall_only ? IDLE : RD_HOLD;
          end
        end else if (tmo_hit) begin
          mem_req_next  = 1'b0;
          err           = 1'b1;
          data_out_next = 8'hFF;
          late_next     = 1'b0;
          data_oe_next  = ~(late_reg | fall_only);
          state_next    = (late_reg | fall_only) ? IDLE : RD_HOLD;
        end else if (fall_only && !late_reg) begin
          // PHI2 fell before the data arrived: poison the read, wait out the ack.
          err           = 1'b1;
          data_out_next = 8'hFF;
          late_next     = 1'b1;
        end
      end
      RD_HOLD: begin
        if (fall_only) begin
          data_oe_next = 1'b0;
          state_next   = IDLE;
        end
      end
      WR_WAIT: begin
        if (fall_only) begin
          mem_wdata_next = data_in;
          mem_req_next   = 1'b1;
          state_next     = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end else if (tmo_hit) begin
          mem_req_next = 1'b0;
          err          = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        data_oe_next = 1'b0;
      end
    endcase

    // A new error outranks a simultaneous clear.
    bus_error_next = err ? 1'b1 : (err_clr ? 1'b0 : bus_error_reg);
  end

  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign data_out    = data_out_reg;
  assign data_oe     = data_oe_reg;
  assign cycle_count = cycle_count_reg;
  assign bus_error   = bus_error_reg;

endmodule

// File: tb/tb_phi2_bus_cycle.sv
// Directed self-checking bench for phi2_bus_cycle (CNT_W=4; TIMEOUT=8 when BUS_TIMEOUT_EN is defined).
module tb_phi2_bus_cycle;

  logic        sys_clock = 1'b0;
  logic        reset = 1'b1;
  logic        phi2_rise = 1'b0;
  logic        phi2_fall = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [3:0]  cycle_count;
  logic        bus_error;

  int tests = 0;
  int fails = 0;

  phi2_bus_cycle #(
    .ADDR_W(16),
    .CNT_W(4)
`ifdef BUS_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .phi2_rise  (phi2_rise),
    .phi2_fall  (phi2_fall),
    .rw         (rw),
    .addr       (addr),
    .data_in    (data_in),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err_clr    (err_clr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .cycle_count(cycle_count),
    .bus_error  (bus_error)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic step();
    @(posedge sys_clock);
    #1;
    phi2_rise = 1'b0;
    phi2_fall = 1'b0;
    mem_ack   = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // Reset state without any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge sys_clock);
    reset = 1'b1;
    step();

    // Read: rise at N, ack at N+3, fall at N+10.
    phi2_rise = 1'b1; rw = 1'b1; addr = 16'h1234;
    step();
    check("rd_req_n1", 32'(mem_req), 32'd1);
    check("rd_addr", 32'(mem_addr), 32'h1234);
    check("rd_we", 32'(mem_we), 32'd0);
    check("rd_count", 32'(cycle_count), 32'd1);
    step();
    check("rd_req_n2", 32'(mem_req), 32'd1);
    step();
    check("rd_req_n3", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step();
    check("rd_req_n4", 32'(mem_req), 32'd0);
    check("rd_data_n4", 32'(data_out), 32'hA5);
    check("rd_oe_n4", 32'(data_oe), 32'd1);
    for (int i = 0; i < 6; i++) step();
    check("rd_oe_n10", 32'(data_oe), 32'd1);
    phi2_fall = 1'b1;
    step();
    check("rd_oe_n11", 32'(data_oe), 32'd0);
    check("rd_err", 32'(bus_error), 32'd0);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    check("stray_ack_oe", 32'(data_oe), 32'd0);
    check("stray_ack_data", 32'(data_out), 32'hA5);

    // Write, with a second rise during WR_REQ.
    phi2_rise = 1'b1; rw = 1'b0; addr = 16'h0200;
    step();
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_req_wait", 32'(mem_req), 32'd0);
    check("wr_count", 32'(cycle_count), 32'd2);
    step();
    phi2_fall = 1'b1; data_in = 8'h3C;
    step();
    check("wr_wdata", 32'(mem_wdata), 32'h3C);
    check("wr_req_f1", 32'(mem_req), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'h0200);
    phi2_rise = 1'b1; rw = 1'b1; addr = 16'h9999;
    step();
    check("wr_rise_err", 32'(bus_error), 32'd1);
    check("wr_rise_count", 32'(cycle_count), 32'd2);
    check("wr_rise_req", 32'(mem_req), 32'd1);
    check("wr_rise_addr", 32'(mem_addr), 32'h0200);
    mem_ack = 1'b1;
    step();
    check("wr_ack_req", 32'(mem_req), 32'd0);
    err_clr = 1'b1;
    step();
    check("wr_errclr", 32'(bus_error), 32'd0);

    // Late ack: fall precedes ack.
    phi2_rise = 1'b1; rw = 1'b1; addr = 16'h0300;
    step();
    step();
    phi2_fall = 1'b1;
    step();
    check("late_err", 32'(bus_error), 32'd1);
    check("late_data", 32'(data_out), 32'hFF);
    check("late_oe", 32'(data_oe), 32'd0);
    check("late_req_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    step();
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_oe", 32'(data_oe), 32'd0);
    check("late_ack_data", 32'(data_out), 32'hFF);
    err_clr = 1'b1;
    step();
    check("late_errclr", 32'(bus_error), 32'd0);

    // Simultaneous rise+fall in IDLE, then clear racing a new error.
    phi2_rise = 1'b1; phi2_fall = 1'b1; rw = 1'b1; addr = 16'h0400;
    step();
    check("both_err", 32'(bus_error), 32'd1);
    check("both_count", 32'(cycle_count), 32'd3);
    check("both_req", 32'(mem_req), 32'd0);
    err_clr = 1'b1; phi2_rise = 1'b1; phi2_fall = 1'b1;
    step();
    check("clr_vs_err", 32'(bus_error), 32'd1);
    err_clr = 1'b1;
    step();
    check("clr_only", 32'(bus_error), 32'd0);

    // Asynchronous reset during RD_REQ.
    phi2_rise = 1'b1; rw = 1'b1; addr = 16'h0500;
    step();
    check("pre_rst_req", 32'(mem_req), 32'd1);
    check("pre_rst_count", 32'(cycle_count), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_oe", 32'(data_oe), 32'd0);
    check("async_rst_count", 32'(cycle_count), 32'd0);
    #1 reset = 1'b1;
    step();

    // 17 minimum-latency reads: count wraps through 0 back to 1.
    for (int i = 0; i < 17; i++) begin
      phi2_rise = 1'b1; rw = 1'b1; addr = 16'(i);
      step();
      mem_ack = 1'b1; mem_rdata = 8'(8'h40 + i);
      step();
      if (i == 0) begin
        check("minlat_oe", 32'(data_oe), 32'd1);
        check("minlat_data", 32'(data_out), 32'h40);
      end
      phi2_fall = 1'b1;
      step();
      if (i == 15) check("wrap_count16", 32'(cycle_count), 32'd0);
    end
    check("wrap_count17", 32'(cycle_count), 32'd1);
    check("wrap_last_data", 32'(data_out), 32'h50);
    check("wrap_err", 32'(bus_error), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // Read with no ack aborts after 8 request cycles, PHI2 still high.
    phi2_rise = 1'b1; rw = 1'b1; addr = 16'h0600;
    step();
    for (int i = 0; i < 7; i++) begin
      check("tmo_req_high", 32'(mem_req), 32'd1);
      step();
    end
    check("tmo_req_last", 32'(mem_req), 32'd1);
    step();
    check("tmo_req_drop", 32'(mem_req), 32'd0);
    check("tmo_err", 32'(bus_error), 32'd1);
    check("tmo_data", 32'(data_out), 32'hFF);
    check("tmo_oe", 32'(data_oe), 32'd1);
    phi2_fall = 1'b1;
    step();
    check("tmo_fall_oe", 32'(data_oe), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
